// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl -- memory-stage data-memory controller.
// Each 32-bit load or store becomes two 16-bit accesses to an external
// asynchronous SRAM: the low half-word (LO phase), then the high half-word
// (HI phase). Each phase lasts WAIT_CYCLES+1 cycles. `ready` is held low
// while a request is in flight, so the hazard logic can freeze the pipeline.
//
// Optional feature: define MEM_BOUNDS_CHECK_EN to flag accesses outside the
// 512 KiB SRAM window. Out-of-range accesses are then suppressed, and the
// sticky addr_err is set. When the macro is undefined, addr_err is 0 and
// addresses wrap.
//
// Ports:
//   clk, rst          clock, async active-low reset
//   rd_en, wr_en      load / store request (a store wins if both are high)
//   address           byte address; SRAM word 0 sits at BASE_ADDR
//   write_data        store data
//   read_data         load result (registered, held between loads)
//   ready             low while a request waits for completion
//   addr_err          sticky out-of-range flag
//   sram_*            SRAM pins (half-word address, DQ split into in/out/oe,
//                     active-low WE/OE)
module mem_sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        addr_err,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

  localparam logic [3:0] WAIT_C = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        wr_q;
  logic        oor_q;
  logic [31:0] wdata_q;
  logic [31:0] read_data_q;
  logic [17:0] sram_addr_q;

  logic        req;
  logic        phase_end;
  logic [31:0] offset;
  logic        oor;

  assign req       = rd_en | wr_en;
  assign phase_end = (cnt_q == WAIT_C);
  assign offset    = address - BASE_ADDR;

`ifdef MEM_BOUNDS_CHECK_EN
  logic addr_err_q;
  assign oor      = (address < BASE_ADDR) | (|offset[31:19]);
  assign addr_err = addr_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    addr_err_q <= 1'b0;
    else if (state_q == IDLE && req && oor) addr_err_q <= 1'b1;
  end

  logic unused_offset;
  assign unused_offset = ^offset[1:0];
`else
  assign oor      = 1'b0;
  assign addr_err = 1'b0;

  logic unused_offset;
  assign unused_offset = ^{offset[31:19], offset[1:0]};
`endif

  // State register plus the datapath registers that follow it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      wr_q        <= 1'b0;
      oor_q       <= 1'b0;
      wdata_q     <= 32'd0;
      read_data_q <= 32'd0;
      sram_addr_q <= 18'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          cnt_q <= 4'd0;
          if (req) begin
            wr_q        <= wr_en;
            oor_q       <= oor;
            wdata_q     <= write_data;
            sram_addr_q <= {offset[18:2], 1'b0};
          end
        end
        LO, HI: begin
          cnt_q <= phase_end ? 4'd0 : cnt_q + 4'd1;
          // The read is sampled on the last cycle of the phase. The HI sample
          // lands at the edge into DONE, so read_data is complete during DONE.
          if (phase_end && !wr_q && !oor_q) begin
            if (state_q == LO) read_data_q[15:0]  <= sram_dq_in;
            else               read_data_q[31:16] <= sram_dq_in;
          end
          if (phase_end && state_q == LO) sram_addr_q[0] <= 1'b1;
        end
        default: cnt_q <= 4'd0;
      endcase
    end
  end

  // Next-state logic. A dropped request in LO/HI does not abort the access.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = LO;
      LO:      if (phase_end) state_d = HI;
      HI:      if (phase_end) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    sram_dq_out = 16'd0;
    if (state_q == LO || state_q == HI) begin
      if (wr_q) begin
        sram_dq_oe  = 1'b1;
        sram_dq_out = (state_q == LO) ? wdata_q[15:0] : wdata_q[31:16];
        // WE is released on the last phase cycle, so data is held past the strobe.
        sram_we_n   = !(cnt_q < WAIT_C) || oor_q;
      end else begin
        sram_oe_n = 1'b0;
      end
    end
  end

  assign ready     = ~req | (state_q == DONE);
  assign read_data = read_data_q;
  assign sram_addr = sram_addr_q;

endmodule
